// File: rtl/mux_scan_sequencer.sv
// Drives the select lines of an external 8:1 mux across the enabled channels in
// ascending order, lets each channel settle, and captures Y into a per-channel sample register.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               Y,
    output logic               S0,
    output logic               S1,
    output logic               S2,
    output logic               busy,
    output logic               done,
    output logic [7:0]         sample
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         mask_q;
    logic [7:0]         sample_q;
    logic               busy_q;
    logic               done_q;

    logic [2:0]         first_idx_d;
    logic [2:0]         next_idx_d;
    logic               has_next_d;

    // Scanning from the top down leaves the lowest qualifying index in the result.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        first_idx_d = 3'd0;
        next_idx_d  = 3'd0;
        has_next_d  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_idx_d = 3'(i);
            end
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_idx_d = 3'(i);
                has_next_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= 8'h00;
            sample_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sample_q <= 8'h00;
                        if (chan_mask != 8'h00) begin
                            mask_q  <= chan_mask;
                            dwell_q <= dwell;
                            sel_q   <= first_idx_d;
                            cnt_q   <= dwell;
                            busy_q  <= 1'b1;
                            state_q <= SETTLE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    sample_q[sel_q] <= Y;
                    if (has_next_d) begin
                        sel_q   <= next_idx_d;
                        cnt_q   <= dwell_q;
                        state_q <= SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {S2, S1, S0} = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample       = sample_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: models the external 8:1 mux and checks
// scan order, per-channel dwell, done latency, captured samples and reset behaviour.
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] chan_mask;
    logic [3:0] dwell;
    logic       Y;
    logic       S0, S1, S2;
    logic       busy;
    logic       done;
    logic [7:0] sample;

    logic [7:0] mux_vec;
    logic [2:0] sel;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Per-scan observations filled in by watch_scan.
    int done_cyc;
    int done_len;
    int bad_sel;
    int order_err;
    int busy_seen;
    int sel_cycles [8];

    mux_scan_sequencer #(.DWELL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chan_mask (chan_mask),
        .dwell     (dwell),
        .Y         (Y),
        .S0        (S0),
        .S1        (S1),
        .S2        (S2),
        .busy      (busy),
        .done      (done),
        .sample    (sample)
    );

    assign sel = {S2, S1, S0};
    assign Y   = mux_vec[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents start for exactly one rising edge (edge 0 of the scan).
    task automatic do_start(input logic [7:0] m, input logic [3:0] d);
        @(negedge clk);
        chan_mask = m;
        dwell     = d;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Observes cycles 1..budget after edge 0 at each falling edge.
    task automatic watch_scan(input logic [7:0] m, input int budget);
        int prev;
        done_cyc  = -1;
        done_len  = 0;
        bad_sel   = 0;
        order_err = 0;
        busy_seen = 0;
        prev      = -1;
        for (int k = 0; k < 8; k++) sel_cycles[k] = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_seen++;
                sel_cycles[sel]++;
                if (!m[sel]) bad_sel++;
                if (int'(sel) < prev) order_err++;
                prev = int'(sel);
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                done_len++;
            end else if (done_cyc >= 0) begin
                break;
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        check_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        start     = 1'b0;
        chan_mask = 8'h00;
        dwell     = 4'd0;
        mux_vec   = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check_cnt++;
        if ({sel, busy, done, sample} !== 13'd0)
            $display("FAIL reset_state: got sel=%0d busy=%b done=%b sample=%h expected all zero",
                     sel, busy, done, sample);
        else pass_cnt++;
        // Release at a falling edge: the very next rising edge must accept a start.
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_scan;
        mux_vec = 8'b1010_0101;
        do_start(8'hFF, 4'd0);
        watch_scan(8'hFF, 40);
        check_int("full_done_cycle", done_cyc, 17);
        check_int("full_done_len", done_len, 1);
        check_int("full_order", order_err, 0);
        check_cnt++;
        if (sample !== 8'hA5) $display("FAIL full_sample: got %h expected a5", sample);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) check_int($sformatf("full_ch%0d_cycles", k), sel_cycles[k], 2);
        // Sample and select lines hold while idle.
        mux_vec = 8'h00;
        repeat (4) @(negedge clk);
        check_cnt++;
        if (sample !== 8'hA5 || sel !== 3'd7)
            $display("FAIL full_hold: got sample=%h sel=%0d expected a5 and 7", sample, sel);
        else pass_cnt++;
    endtask

    task automatic test_sparse_mask;
        mux_vec = 8'hFF;
        do_start(8'b1000_0010, 4'd3);
        watch_scan(8'b1000_0010, 40);
        check_int("sparse_done_cycle", done_cyc, 11);
        check_int("sparse_bad_sel", bad_sel, 0);
        check_int("sparse_ch1_cycles", sel_cycles[1], 5);
        check_int("sparse_ch7_cycles", sel_cycles[7], 5);
        check_cnt++;
        if (sample !== 8'h82) $display("FAIL sparse_sample: got %h expected 82", sample);
        else pass_cnt++;
    endtask

    task automatic test_empty_mask;
        mux_vec = 8'hFF;
        do_start(8'h00, 4'd5);
        watch_scan(8'h00, 10);
        check_int("empty_done_cycle", done_cyc, 1);
        check_int("empty_done_len", done_len, 1);
        check_int("empty_busy_cycles", busy_seen, 0);
        check_cnt++;
        if (sample !== 8'h00) $display("FAIL empty_sample: got %h expected 00", sample);
        else pass_cnt++;
    endtask

    task automatic test_start_in_done;
        // Edge 0 enters DONE; start stays high with a live mask at edge 1 and must be ignored.
        @(negedge clk);
        chan_mask = 8'h00;
        dwell     = 4'd0;
        start     = 1'b1;
        @(posedge clk);
        #1 chan_mask = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL start_in_done: got busy=%b done=%b expected 0 0", busy, done);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_scan_disturb;
        mux_vec = 8'b0101_1010;
        do_start(8'h0F, 4'd1);
        fork
            watch_scan(8'h0F, 40);
            begin
                repeat (3) @(posedge clk);
                #1 chan_mask = 8'h00;
                dwell = 4'd9;
                start = 1'b1;
                repeat (2) @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check_int("disturb_done_cycle", done_cyc, 13);
        check_int("disturb_busy_cycles", busy_seen, 12);
        check_int("disturb_bad_sel", bad_sel, 0);
        check_cnt++;
        if (sample !== 8'h0A) $display("FAIL disturb_sample: got %h expected 0a", sample);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan;
        int found;
        int done_seen;
        mux_vec = 8'h0F;
        do_start(8'h0F, 4'd3);
        found = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy && sel == 3'd3) begin
                found = 1;
                break;
            end
        end
        check_int("rst_reached_ch3", found, 1);
        check_cnt++;
        if (sample !== 8'h07) $display("FAIL rst_pre_sample: got %h expected 07", sample);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({sel, busy, done, sample} !== 13'd0)
            $display("FAIL rst_async: got sel=%0d busy=%b done=%b sample=%h expected all zero",
                     sel, busy, done, sample);
        else pass_cnt++;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_int("rst_no_done", done_seen, 0);
        rst_n   = 1'b1;
        mux_vec = 8'h01;
        do_start(8'h01, 4'd0);
        watch_scan(8'h01, 20);
        check_int("rst_after_done_cycle", done_cyc, 3);
        check_cnt++;
        if (sample !== 8'h01) $display("FAIL rst_after_sample: got %h expected 01", sample);
        else pass_cnt++;
    endtask

    task automatic test_max_dwell;
        mux_vec = 8'hFE;
        do_start(8'h01, 4'd15);
        watch_scan(8'h01, 40);
        check_int("maxdwell_done_cycle", done_cyc, 18);
        check_int("maxdwell_ch0_cycles", sel_cycles[0], 17);
        check_cnt++;
        if (sample !== 8'h00) $display("FAIL maxdwell_sample: got %h expected 00", sample);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_full_scan;
        test_sparse_mask;
        test_empty_mask;
        test_start_in_done;
        test_mid_scan_disturb;
        test_reset_mid_scan;
        test_max_dwell;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
